// File: rtl/timer_counter.sv
// timer_counter: programmable down-counting timer feeding one CP0 HWInt line.
//
// Registers (word address on addr):
//   0 CTRL   : bit0 EN (count enable), bits2:1 MODE (1 = auto-reload, else one-shot),
//              bit3 IM (interrupt mask, 1 = irq allowed); other bits write-ignored, read 0
//   1 PRESET : reload value, R/W
//   2 COUNT  : current count, read-only
//   3        : reserved, reads 0, writes ignored
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-low reset
//   addr   in   2      register select
//   we     in   1      write strobe, sampled on the rising edge
//   wdata  in   WIDTH  write data
//   rdata  out  WIDTH  combinational read of the selected register
//   irq    out  1      registered interrupt request (pend & IM)
module timer_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e           state_q;
    logic             en_q;
    logic [1:0]       mode_q;
    logic             im_q;
    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] count_q;
    logic             pend_q;
    logic             irq_q;

    logic wr_ctrl;
    logic wr_preset;
    logic one_shot;
    logic pend_set;
    logic pend_d;
    logic im_d;

    always_comb begin
        wr_ctrl   = we && (addr == 2'd0);
        wr_preset = we && (addr == 2'd1);
        // MODE values 2 and 3 fall back to one-shot behaviour.
        one_shot  = (mode_q != 2'd1);
        // Terminal count: COUNT of 1 or 0 both fire, so PRESET=0 acts as PRESET=1.
        pend_set  = (state_q == StCnt) && en_q && (count_q <= CountOne);
        im_d      = wr_ctrl ? wdata[3] : im_q;

        // A set always beats a clear landing on the same edge.
        pend_d = pend_q;
        if (pend_set) begin
            pend_d = 1'b1;
        end else if (pend_q && !one_shot) begin
            pend_d = 1'b0;
        end else if (pend_q && one_shot && (wr_ctrl || wr_preset)) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            en_q     <= 1'b0;
            mode_q   <= 2'd0;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en_q) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!en_q) begin
                        state_q <= StIdle;
                    end else if (count_q > CountOne) begin
                        count_q <= count_q - CountOne;
                    end else begin
                        count_q <= '0;
                        state_q <= StInt;
                    end
                end
                StInt: begin
                    if (one_shot) begin
                        en_q    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= en_q ? StLoad : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Bus writes come last so they override the one-shot EN clear.
            if (wr_ctrl) begin
                en_q   <= wdata[0];
                mode_q <= wdata[2:1];
                im_q   <= wdata[3];
            end
            if (wr_preset) begin
                preset_q <= wdata;
            end

            pend_q <= pend_d;
            irq_q  <= pend_d & im_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata[3:0] = {im_q, mode_q, en_q};
            2'd1:    rdata      = preset_q;
            2'd2:    rdata      = count_q;
            default: rdata      = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   addr;
    logic         we;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         irq;

    always #5 clk = ~clk;

    timer_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    typedef struct {
        logic [W-1:0] rdata;
        logic         irq;
        logic [1:0]   addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rise_q[$];
    int   width_q[$];
    int   rise_cyc = 0;
    logic irq_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int PhIdle = 0, PhLoad = 1, PhCount = 2, PhInt = 3;
    int           m_phase;
    bit           m_en, m_im, m_pend, m_irq;
    bit [1:0]     m_mode;
    bit [W-1:0]   m_preset, m_count;

    function automatic void model_reset();
        m_phase = PhIdle; m_en = 0; m_im = 0; m_mode = 0;
        m_pend = 0; m_irq = 0; m_preset = '0; m_count = '0;
    endfunction

    function automatic void model_edge(input logic [1:0] a, input logic w, input logic [W-1:0] d);
        bit       wr_ctrl  = w && (a == 2'd0);
        bit       wr_pre   = w && (a == 2'd1);
        bit       auto_rl  = (m_mode == 2'd1);
        bit       fire     = (m_phase == PhCount) && m_en && (m_count <= 1);
        int       nphase   = m_phase;
        bit       nen      = m_en;
        bit [W-1:0] ncount = m_count;
        if (m_phase == PhIdle) begin
            if (m_en) nphase = PhLoad;
        end else if (m_phase == PhLoad) begin
            ncount = m_preset;
            nphase = PhCount;
        end else if (m_phase == PhCount) begin
            if (!m_en) nphase = PhIdle;
            else if (fire) begin ncount = 0; nphase = PhInt; end
            else ncount = m_count - 1;
        end else begin
            if (!auto_rl) begin nen = 0; nphase = PhIdle; end
            else nphase = m_en ? PhLoad : PhIdle;
        end
        if (fire) m_pend = 1;
        else if (m_pend && auto_rl) m_pend = 0;
        else if (m_pend && (wr_ctrl || wr_pre)) m_pend = 0;
        if (wr_ctrl) begin nen = d[0]; m_mode = d[2:1]; m_im = d[3]; end
        if (wr_pre) m_preset = d;
        m_phase = nphase; m_en = nen; m_count = ncount;
        m_irq = m_pend && m_im;
    endfunction

    function automatic logic [W-1:0] model_read(input logic [1:0] a);
        logic [W-1:0] r = '0;
        if (a == 2'd0) r[3:0] = {m_im, m_mode, m_en};
        else if (a == 2'd1) r = m_preset;
        else if (a == 2'd2) r = m_count;
        return r;
    endfunction

    // ---------------- driver ----------------
    logic         cur_rst = 1'b0;
    logic [1:0]   cur_addr = 2'd0;
    logic         cur_we = 1'b0;
    logic [W-1:0] cur_wdata = '0;

    task automatic step(input logic rst_v, input logic [1:0] a, input logic w, input logic [W-1:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        if (!cur_rst) model_reset();
        else model_edge(cur_addr, cur_we, cur_wdata);
        reset = rst_v; addr = a; we = w; wdata = d;
        cur_rst = rst_v; cur_addr = a; cur_we = w; cur_wdata = d;
        if (!rst_v) model_reset();
        e.rdata = model_read(a);
        e.irq   = m_irq;
        e.addr  = a;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        step(1'b1, a, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, W'($urandom));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("rdata_addr%0d", e.addr), rdata, e.rdata);
            check("irq", W'(irq), W'(e.irq));
        end
        if (irq === 1'b1 && irq_prev === 1'b0) begin
            rise_q.push_back(cyc);
            rise_cyc = cyc;
        end
        if (irq === 1'b0 && irq_prev === 1'b1) width_q.push_back(cyc - rise_cyc);
        irq_prev = irq;
    end

    initial begin
        int r0, w0, n0, waited;
        reset = 1'b0; addr = 2'd0; we = 1'b0; wdata = '0;
        model_reset();

        // Reset values on every address.
        for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 1'b0, '0);
        step(1'b1, 2'd0, 1'b0, '0);

        // Reset mid-count aborts silently.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        idle(4);
        step(1'b0, 2'd2, 1'b0, '0);
        step(1'b0, 2'd0, 1'b0, '0);
        step(1'b1, 2'd2, 1'b0, '0);
        n0 = rise_q.size();
        idle(20);
        check("no_irq_after_reset", W'(rise_q.size()), W'(n0));

        // One-shot: irq rises after E6 and holds; EN self-clears.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        r0 = cyc;
        n0 = rise_q.size();
        for (int i = 0; i < 12; i++) step(1'b1, 2'(i % 3), 1'b0, '0);
        check("oneshot_rises", W'(rise_q.size()), W'(n0 + 1));
        if (rise_q.size() > n0) check("oneshot_latency", W'(rise_q[n0]), W'(r0 + 7));
        wr(2'd0, 32'h8);
        idle(3);

        // Auto-reload: period N+2 = 5, one-cycle pulses.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        n0 = rise_q.size();
        w0 = width_q.size();
        idle(52);
        check("autoreload_pulse_count_ge10", W'(rise_q.size() - n0 >= 10), W'(1));
        for (int i = n0 + 1; i < rise_q.size(); i++)
            check("autoreload_period", W'(rise_q[i] - rise_q[i-1]), W'(5));
        for (int i = w0; i < width_q.size(); i++)
            check("autoreload_width", W'(width_q[i]), W'(1));
        wr(2'd0, 32'h8);
        idle(3);
        n0 = rise_q.size();
        idle(12);
        check("autoreload_stopped", W'(rise_q.size()), W'(n0));

        // Mask, then CTRL write colliding with the pend-set edge.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        idle(3);
        wr(2'd0, 32'h8);
        idle(4);
        // Plain CTRL write clears the held request.
        wr(2'd0, 32'h8);
        idle(4);
        // PRESET write also clears a one-shot request.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        idle(6);
        wr(2'd1, 32'd7);
        idle(4);

        // Mid-count PRESET write in auto-reload.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'hB);
        waited = 0;
        while (!(m_phase == PhCount && m_count == 6) && waited < 40) begin
            step(1'b1, 2'd2, 1'b0, '0);
            waited++;
        end
        if (waited >= 40) begin
            checks++;
            failures++;
            $display("FAIL wait_count6: timed out after %0d cycles, required count 6", waited);
        end
        wr(2'd1, 32'd2);
        n0 = rise_q.size();
        idle(30);
        for (int i = n0 + 1; i < rise_q.size(); i++)
            check("reload_new_period", W'(rise_q[i] - rise_q[i-1]), W'(4));
        wr(2'd0, 32'h0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int op = $urandom_range(0, 99);
            if (op < 1) step(1'b0, 2'($urandom_range(0, 3)), 1'b0, '0);
            else if (op < 12) wr(2'd1, W'($urandom_range(0, 6)));
            else if (op < 22) wr(2'd0, W'($urandom_range(0, 15)));
            else if (op < 26) wr(2'($urandom_range(0, 3)), W'($urandom));
            else step(1'b1, 2'($urandom_range(0, 3)), 1'b0, W'($urandom));
        end

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
